seq_detect_ctrl: RTL and testbench

Programmable serial pattern-detection controller. It holds the detector configuration (pattern, length, overlap mode, match limit) and sequences a run from arm through detection to completion. It counts matches and reports completion and errors. It sits between a register/config master and a serial bit stream, and generalises the fixed-pattern Mealy detectors into one run-time-configured, controlled engine.

---
 rtl/seq_detect_ctrl.sv | 126 ++++++++++++
 tb/tb_seq_detect_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - run-time configurable serial pattern detector with arm/run/done control
// Holds pattern/len/overlap/limit config and sequences a detection run, counting matches.
module seq_detect_ctrl #(
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_pattern,
  input  logic [3:0]    cfg_len,
  input  logic          cfg_overlap,
  input  logic [CW-1:0] cfg_limit,
  input  logic          start,
  input  logic          stop,
  input  logic          signal,
  input  logic          signal_valid,
  output logic          out,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] match_count
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  localparam logic [PW-1:0] DEF_PATTERN = PW'(11);

  state_t        state, state_n;
  logic [PW-1:0] pat_q;
  logic [3:0]    len_q;
  logic          ovl_q;
  logic [CW-1:0] lim_q;
  logic [PW-1:0] shreg, shreg_n;
  logic [3:0]    fill, fill_n;
  logic [CW-1:0] count_n;
  logic          match_n;
  logic          err_n;
  logic [3:0]    eff_len;
  logic          len_bad;
  logic [PW-1:0] mask;

  always_comb begin
    // a start that coincides with a config write is judged on the value being written
    eff_len = cfg_we ? cfg_len : len_q;
    len_bad = (eff_len == 4'd0) || (int'(eff_len) > PW);
    for (int i = 0; i < PW; i++) begin
      mask[i] = (i < int'(len_q));
    end

    state_n = state;
    shreg_n = shreg;
    fill_n  = fill;
    count_n = match_count;
    match_n = 1'b0;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (len_bad) err_n = 1'b1;
          else         state_n = ARM;
        end
      end
      ARM: begin
        shreg_n = '0;
        fill_n  = 4'd0;
        count_n = '0;
        state_n = RUN;
      end
      RUN: begin
        // stop wins: a same-cycle bit is dropped unconsumed
        if (stop) begin
          state_n = IDLE;
        end else if (signal_valid) begin
          shreg_n = {shreg[PW-2:0], signal};
          if (fill < len_q) fill_n = fill + 4'd1;
          if ((fill_n >= len_q) && ((shreg_n & mask) == (pat_q & mask))) begin
            match_n = 1'b1;
            if (match_count != '1) count_n = match_count + CW'(1);
            if (!ovl_q) fill_n = 4'd0;
            if ((lim_q != '0) && (count_n == lim_q)) state_n = DONE;
          end
        end
      end
      DONE: begin
        if (stop)       state_n = IDLE;
        else if (start) state_n = ARM;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pat_q       <= DEF_PATTERN;
      len_q       <= 4'd4;
      ovl_q       <= 1'b0;
      lim_q       <= '0;
      shreg       <= '0;
      fill        <= 4'd0;
      match_count <= '0;
      out         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      if ((state == IDLE) && cfg_we) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
        lim_q <= cfg_limit;
      end
      state       <= state_n;
      shreg       <= shreg_n;
      fill        <= fill_n;
      match_count <= count_n;
      out         <= match_n;
      err         <= err_n;
      busy        <= (state_n == ARM) || (state_n == RUN);
      done        <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed self-checking bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_limit = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       signal = 1'b0;
  logic       signal_valid = 1'b0;
  logic       out, busy, done, err;
  logic [7:0] match_count;

  int tests = 0;
  int fails = 0;
  logic [15:0] outs;

  seq_detect_ctrl #(.PW(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
    .start(start), .stop(stop), .signal(signal), .signal_valid(signal_valid),
    .out(out), .busy(busy), .done(done), .err(err), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] lim);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_limit = lim;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic arm_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // bits[n-1] goes first; out after each bit is collected MSB-first into o
  task automatic stream(input logic [15:0] bits, input int n, output logic [15:0] o);
    o = '0;
    for (int i = n - 1; i >= 0; i--) begin
      signal = bits[i];
      signal_valid = 1'b1;
      tick();
      o = {o[14:0], out};
    end
    signal_valid = 1'b0;
    signal = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_count", match_count, 0);
    rst = 1'b1;
    tick();

    // default config, non-overlapping
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy_arm", busy, 1);
    tick();
    stream(16'b1011011, 7, outs);
    check("t1_outs", outs, 16'b0001000);
    check("t1_count", match_count, 1);
    check("t1_busy", busy, 1);
    halt();
    check("t1_busy_stop", busy, 0);

    // overlapping
    write_cfg(8'b0000_1011, 4'd4, 1'b1, 8'd0);
    arm_run();
    stream(16'b1011011, 7, outs);
    check("t2_outs", outs, 16'b0001001);
    check("t2_count", match_count, 2);
    halt();

    // limit 2, auto-stop
    write_cfg(8'b0000_0101, 4'd3, 1'b1, 8'd2);
    arm_run();
    stream(16'b10101, 5, outs);
    check("t3_outs", outs, 16'b00101);
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);
    stream(16'b1, 1, outs);
    check("t3_out_ignored", outs, 0);
    check("t3_count_hold", match_count, 2);
    check("t3_done_hold", done, 1);
    halt();
    check("t3_done_stop", done, 0);

    // rejected start
    write_cfg(8'b0000_1011, 4'd0, 1'b0, 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_err", err, 1);
    check("t4_busy", busy, 0);
    tick();
    check("t4_err_pulse", err, 0);
    check("t4_busy_idle", busy, 0);
    write_cfg(8'b0000_1011, 4'd4, 1'b0, 8'd1);
    arm_run();
    stream(16'b1011, 4, outs);
    check("t4_outs", outs, 16'b0001);
    check("t4_done", done, 1);
    halt();

    // stop beats a same-cycle bit; cfg_we in RUN ignored
    arm_run();
    cfg_pattern = 8'b0; cfg_len = 4'd3; cfg_overlap = 1'b1; cfg_limit = 8'd0;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    stream(16'b101, 3, outs);
    check("t5_outs", outs, 0);
    stop = 1'b1; signal = 1'b1; signal_valid = 1'b1;
    tick();
    stop = 1'b0; signal = 1'b0; signal_valid = 1'b0;
    check("t5_out", out, 0);
    check("t5_busy", busy, 0);
    check("t5_count", match_count, 0);
    arm_run();
    stream(16'b1011, 4, outs);
    check("t5_cfg_kept", outs, 16'b0001);
    check("t5_cfg_limit", done, 1);
    halt();

    // reset mid-run restores defaults
    arm_run();
    stream(16'b10, 2, outs);
    rst = 1'b0;
    tick();
    check("t6_out", out, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_err", err, 0);
    check("t6_count", match_count, 0);
    rst = 1'b1;
    arm_run();
    stream(16'b1011, 4, outs);
    check("t6_outs", outs, 16'b0001);
    check("t6_count_after", match_count, 1);
    check("t6_no_limit", done, 0);
    check("t6_busy_after", busy, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
